// File: rtl/tohost_pkg.sv
// rtl/tohost_pkg.sv - shared state encoding, ASCII constants and report lengths for tohost_monitor
package tohost_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REPORT   = 2'd1,
        ST_FINISHED = 2'd2
    } state_t;

    localparam logic [7:0] CH_P  = 8'h50;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_F  = 8'h46;
    localparam logic [7:0] CH_I  = 8'h49;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_NL = 8'h0A;

    localparam int PASS_LEN = 5;
    localparam int FAIL_LEN = 8;

    function automatic logic [2:0] last_index(input logic is_pass);
        return is_pass ? 3'(PASS_LEN - 1) : 3'(FAIL_LEN - 1);
    endfunction

endpackage

// File: rtl/tohost_monitor_if.sv
// rtl/tohost_monitor_if.sv - store bus and optional verdict byte stream (TOHOST_REPORT_EN)
interface tohost_monitor_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
`ifdef TOHOST_REPORT_EN
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`endif

    modport master (
        output wr_en, wr_addr, wr_data
`ifdef TOHOST_REPORT_EN
        , input tx_data, tx_valid
        , output tx_ready
`endif
    );

    modport slave (
        input wr_en, wr_addr, wr_data
`ifdef TOHOST_REPORT_EN
        , output tx_data, tx_valid
        , input tx_ready
`endif
    );
endinterface

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - 4-bit value to uppercase hex ASCII; built only with TOHOST_REPORT_EN
`ifdef TOHOST_REPORT_EN
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb begin
        if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
        else                ascii = 8'h37 + {4'h0, nibble};
    end
endmodule
`endif

// File: rtl/tohost_monitor.sv
// rtl/tohost_monitor.sv - captures the riscv-tests tohost write, raises halt, optionally streams a verdict
// Optional verdict stream compiled in with TOHOST_REPORT_EN.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
    input  logic               clk,
    input  logic               rst,
    tohost_monitor_if.slave    bus,
    output logic               done,
    output logic               pass,
    output logic [30:0]        test_num,
    output logic               halt_req
);

    state_t state, state_next;
    logic   hit_term;

    // Only odd values terminate; even values are syscall-style traffic.
    assign hit_term = bus.wr_en && (bus.wr_addr == TOHOST_ADDR) &&
                      (state == ST_IDLE) && bus.wr_data[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            pass     <= 1'b0;
            test_num <= 31'd0;
        end else begin
            state <= state_next;
            if (hit_term) begin
                pass     <= (bus.wr_data == 32'h1);
                test_num <= bus.wr_data[31:1];
            end
        end
    end

`ifdef TOHOST_REPORT_EN
    logic [2:0] idx;
    logic [7:0] hex_hi, hex_lo, rom_byte;
    logic       beat, last_beat;

    assign beat      = bus.tx_valid && bus.tx_ready;
    assign last_beat = (idx == last_index(pass));

    always_ff @(posedge clk) begin
        if (rst || state != ST_REPORT) idx <= 3'd0;
        else if (beat)                 idx <= idx + 3'd1;
    end

    nibble_to_ascii u_hex_hi (.nibble(test_num[7:4]), .ascii(hex_hi));
    nibble_to_ascii u_hex_lo (.nibble(test_num[3:0]), .ascii(hex_lo));

    always_comb begin
        rom_byte = 8'h00;
        if (pass) begin
            case (idx)
                3'd0:    rom_byte = CH_P;
                3'd1:    rom_byte = CH_A;
                3'd2:    rom_byte = CH_S;
                3'd3:    rom_byte = CH_S;
                3'd4:    rom_byte = CH_NL;
                default: rom_byte = 8'h00;
            endcase
        end else begin
            case (idx)
                3'd0:    rom_byte = CH_F;
                3'd1:    rom_byte = CH_A;
                3'd2:    rom_byte = CH_I;
                3'd3:    rom_byte = CH_L;
                3'd4:    rom_byte = CH_SP;
                3'd5:    rom_byte = hex_hi;
                3'd6:    rom_byte = hex_lo;
                default: rom_byte = CH_NL;
            endcase
        end
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (hit_term) begin
`ifdef TOHOST_REPORT_EN
                    state_next = ST_REPORT;
`else
                    state_next = ST_FINISHED;
`endif
                end
            end
            ST_REPORT: begin
`ifdef TOHOST_REPORT_EN
                if (beat && last_beat) state_next = ST_FINISHED;
`else
                state_next = ST_FINISHED;
`endif
            end
            ST_FINISHED: state_next = ST_FINISHED;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        done     = (state != ST_IDLE);
        halt_req = (state != ST_IDLE);
`ifdef TOHOST_REPORT_EN
        bus.tx_valid = (state == ST_REPORT);
        bus.tx_data  = (state == ST_REPORT) ? rom_byte : 8'h00;
`endif
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// tb/tb_tohost_monitor.sv - directed bench with a string-level verdict model for tohost_monitor
module tb_tohost_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        done, pass, halt_req;
    logic [30:0] test_num;

    int vectors = 0;
    int miscompares = 0;

    tohost_monitor_if bif();

    tohost_monitor #(.TOHOST_ADDR(32'h0000_1000)) dut (
        .clk(clk), .rst(rst), .bus(bif.slave),
        .done(done), .pass(pass), .test_num(test_num), .halt_req(halt_req)
    );

    always #5 clk = ~clk;

    logic        m_done, m_pass;
    logic [30:0] m_tn;
    logic [7:0]  mq[$];
    logic [7:0]  rx[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] hexch(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
    endfunction

    // Model: the verdict is a string decided at capture time and drained on handshakes.
    always @(posedge clk) begin
        if (rst) begin
            m_done = 1'b0; m_pass = 1'b0; m_tn = '0;
            mq.delete(); rx.delete();
        end else begin
`ifdef TOHOST_REPORT_EN
            if (bif.tx_valid && bif.tx_ready) rx.push_back(bif.tx_data);
            if (mq.size() > 0 && bif.tx_ready) void'(mq.pop_front());
`endif
            if (bif.wr_en && bif.wr_addr == 32'h1000 && !m_done && bif.wr_data[0]) begin
                m_done = 1'b1;
                m_pass = (bif.wr_data == 32'd1);
                m_tn   = bif.wr_data[31:1];
`ifdef TOHOST_REPORT_EN
                if (m_pass) mq = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
                else        mq = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h20,
                                   hexch(m_tn[7:4]), hexch(m_tn[3:0]), 8'h0A};
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst !== 1'bx) begin
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("pass", {31'd0, pass}, {31'd0, m_pass});
            chk("test_num", {1'b0, test_num}, {1'b0, m_tn});
            chk("halt_req", {31'd0, halt_req}, {31'd0, m_done});
`ifdef TOHOST_REPORT_EN
            chk("tx_valid", {31'd0, bif.tx_valid}, {31'd0, mq.size() > 0});
            chk("tx_data", {24'd0, bif.tx_data}, {24'd0, (mq.size() > 0) ? mq[0] : 8'h00});
`endif
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bif.wr_en = 1'b1; bif.wr_addr = a; bif.wr_data = d;
        @(negedge clk);
        bif.wr_en = 1'b0;
    endtask

    task automatic wait_report();
`ifdef TOHOST_REPORT_EN
        int n = 0;
        while (bif.tx_valid && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) chk("report_timeout", 32'd1, 32'd0);
`else
        repeat (2) @(negedge clk);
`endif
    endtask

    task automatic chk_rx(input string nm, input logic [7:0] exp[$]);
        chk({nm, "_len"}, rx.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx.size(); i++)
            chk(nm, {24'd0, rx[i]}, {24'd0, exp[i]});
    endtask

    initial begin
        logic [7:0] pass_str[$];
        logic [7:0] fail7_str[$];
        pass_str  = '{8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
        fail7_str = '{8'h46, 8'h41, 8'h49, 8'h4C, 8'h20, 8'h30, 8'h33, 8'h0A};
        rst = 1'b1;
        bif.wr_en = 1'b0; bif.wr_addr = '0; bif.wr_data = '0;
`ifdef TOHOST_REPORT_EN
        bif.tx_ready = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        do_write(32'h1000, 32'h2);
        do_write(32'h1004, 32'h1);
        chk("ignored_done", {31'd0, done}, 32'd0);

        do_write(32'h1000, 32'h1);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_pass", {31'd0, pass}, 32'd1);
        chk("pass_tn", {1'b0, test_num}, 32'd0);
        chk("pass_halt", {31'd0, halt_req}, 32'd1);
        wait_report();
`ifdef TOHOST_REPORT_EN
        chk_rx("pass_bytes", pass_str);
`endif
        do_write(32'h1000, 32'h7);
        chk("sticky_pass", {31'd0, pass}, 32'd1);
        chk("sticky_tn", {1'b0, test_num}, 32'd0);

        do_reset();
        do_write(32'h1000, 32'h7);
        chk("fail7_pass", {31'd0, pass}, 32'd0);
        chk("fail7_tn", {1'b0, test_num}, 32'd3);
        wait_report();
`ifdef TOHOST_REPORT_EN
        chk_rx("fail7_bytes", fail7_str);
`endif

        do_reset();
        do_write(32'h1000, 32'h155);
        chk("fail155_tn", {1'b0, test_num}, 32'hAA);
        wait_report();
`ifdef TOHOST_REPORT_EN
        chk("fail155_len", rx.size(), 32'd8);
        if (rx.size() == 8) begin
            chk("fail155_hi", {24'd0, rx[5]}, 32'h41);
            chk("fail155_lo", {24'd0, rx[6]}, 32'h41);
        end
`endif

        // rst together with a hit: nothing captured
        do_reset();
        @(negedge clk);
        rst = 1'b1; bif.wr_en = 1'b1; bif.wr_addr = 32'h1000; bif.wr_data = 32'h1;
        @(negedge clk);
        rst = 1'b0; bif.wr_en = 1'b0;
        chk("rst_hit_done", {31'd0, done}, 32'd0);

`ifdef TOHOST_REPORT_EN
        begin
            int held = 0;
            do_write(32'h1000, 32'h1);
            for (int c = 0; c < 20 && bif.tx_valid; c++) begin
                if (bif.tx_data == 8'h41) held++;
                bif.tx_ready = !(c >= 1 && c <= 3);
                @(negedge clk);
            end
            bif.tx_ready = 1'b1;
            chk("bp_hold_cycles", held, 32'd4);
            chk_rx("bp_bytes", pass_str);
        end

        do_reset();
        do_write(32'h1000, 32'h7);
        begin
            int n = 0;
            while (rx.size() < 3 && n < 20) begin @(negedge clk); n++; end
            chk("mid_reached", rx.size(), 32'd3);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_done", {31'd0, done}, 32'd0);
        chk("mid_tn", {1'b0, test_num}, 32'd0);
        chk("mid_valid", {31'd0, bif.tx_valid}, 32'd0);
        chk("mid_data", {24'd0, bif.tx_data}, 32'd0);
        rst = 1'b0;
        do_write(32'h1000, 32'h1);
        wait_report();
        chk_rx("after_rst_bytes", pass_str);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Memory-mapped responder on the core's data-store path that captures the riscv-tests `tohost` write. It decodes the word into done, pass and test-number flags and raises a halt request to the core. Optionally it streams an ASCII verdict byte-by-byte to a downstream transmitter. It is the in-hardware counterpart of bench-side pass/fail inspection, so results are visible on FPGA without probing the register file.

## Interface

Parameters:
- TOHOST_ADDR, 32'h0000_1000, byte address of the `tohost` word; matched on all 32 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store strobe from the core's memory stage; one store per cycle.
- wr_addr  in  32  store byte address.
- wr_data  in  32  store data, full word.
- done  out  1  a terminating `tohost` write has been captured; sticky.
- pass  out  1  valid when done; 1 means wr_data == 1.
- test_num  out  31  wr_data[31:1] of the captured word; 0 on pass.
- halt_req  out  1  request to the core to stop fetching; equals done.
- tx_data  out  8  ASCII byte; only present with TOHOST_REPORT_EN.
- tx_valid  out  1  tx_data is valid; only present with TOHOST_REPORT_EN.
- tx_ready  in  1  downstream accepts byte; only present with TOHOST_REPORT_EN.

## Operation

- **Hit condition:** wr_en && wr_addr == TOHOST_ADDR && !done.
- **Terminating write:** a hit with wr_data[0] == 1 latches done=1, pass=(wr_data == 32'h1), and test_num=wr_data[31:1].
- **Non-terminating write:** a hit with wr_data[0] == 0 (syscall-style) is ignored; no state change.
- **After done:** all writes are ignored until rst.
- **States:** IDLE → REPORT → FINISHED.
  - IDLE → REPORT on a terminating hit.
  - REPORT → FINISHED when the last byte handshakes.
  - Without TOHOST_REPORT_EN, IDLE → FINISHED directly.
- **Report strings:**
  - Pass: "PASS\n", 5 bytes (0x50 0x41 0x53 0x53 0x0A).
  - Fail: "FAIL hh\n", 8 bytes, where hh is test_num[7:0] as two uppercase hex digits, high nibble first. Digits 0–9 map to 0x30+n; A–F map to 0x37+n.
- **Byte index:** a 3-bit counter. It advances only on tx_valid && tx_ready.
- **Reset mid-report:** rst aborts the transmission, returns to IDLE, and clears all outputs. No partial-string resumption.

## Timing

- **Reset values:** done=0, pass=0, test_num=0, halt_req=0, tx_valid=0, tx_data=8'h00, state IDLE, index 0.
- **Capture latency:** a hit at edge N makes done, pass, test_num and halt_req visible after edge N (registered, 1 cycle).
- **Report start:** tx_valid rises in the same cycle as done. tx_data is then the first byte.
- **Handshake:**
  - tx_data and tx_valid hold stable while tx_valid && !tx_ready.
  - A byte is consumed on an edge where both are high; the next byte appears after that edge.
  - With tx_ready tied high, the report takes exactly 5 cycles (pass) or 8 cycles (fail).
  - tx_valid drops after the last byte's handshake edge.
- **Simultaneous rst and hit:** rst wins; nothing is captured.

## Configuration

- **TOHOST_REPORT_EN defined:** tx_* ports, the REPORT state, the byte index and the ASCII ROM are compiled in.
- **TOHOST_REPORT_EN undefined:**
  - tx_* ports are absent and no report state exists.
  - done, pass, test_num and halt_req behave identically to the defined case.

## Structure

- **Shared package tohost_pkg:**
  - state encoding (IDLE, REPORT, FINISHED);
  - ASCII constants for 'P', 'A', 'S', 'F', 'I', 'L', space and newline;
  - the string lengths PASS_LEN=5 and FAIL_LEN=8.
- **Sub-module nibble_to_ascii:** 4-bit in, 8-bit uppercase hex character out. Instanced twice for the fail digits.

## Test plan

- **Pass:** write 32'h1 to 32'h1000 → next cycle done=1, pass=1, test_num=0, halt_req=1. With tx_ready=1, bytes 50 41 53 53 0A arrive on 5 consecutive cycles, then tx_valid=0.
- **Fail:** write 32'h0000_0007 → pass=0, test_num=3, bytes 46 41 49 4C 20 30 33 0A. Write 32'h0000_0155 → test_num=0xAA, digits 41 41.
- **Ignored writes:**
  - 32'h2 to TOHOST_ADDR → done stays 0.
  - 32'h1 to 32'h1004 → done stays 0.
  - A second terminating write after done leaves pass and test_num unchanged.
- **Backpressure:** pass case with tx_ready low for 3 cycles on byte 2 → tx_data holds 41 for 4 cycles. Total bytes still exactly 5; no duplicates or skips.
- **Reset mid-report:** assert rst after the 3rd fail byte → next cycle all outputs are 0. A subsequent 32'h1 write produces a full, clean "PASS\n".
- **Build without TOHOST_REPORT_EN:** the pass and fail writes above give identical done, pass, test_num and halt_req values.
